lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Shares the single data-RAM port between two LSU lanes (lane 0, lane 1) of one VLIW bundle.
- Lanes request in their execute stage. Single requests pass straight through to the RAM in the same cycle.
- Same-cycle conflicts are serialised over two cycles. The block asserts a pipeline stall request and buffers the first lane's read data so both lanes see correct writeback data.

Parameters:
- RR_INIT, 0, lane that holds round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- stall_in  in  1  stall from the hazard detection unit (other sources)
- lN_rd_en  in  1  lane N read request (N = 0,1, all lane ports per lane)
- lN_rd_addr  in  32  lane N read address
- lN_rd_size  in  2  lane N read size (0 byte, 1 half, 2 word)
- lN_rd_zero_ext  in  1  lane N zero-extend
- lN_wr_en  in  1  lane N write request
- lN_wr_addr  in  32  lane N write address
- lN_wr_data  in  32  lane N write data
- lN_wr_size  in  2  lane N write size
- lN_rd_data  out  32  read data to lane N writeback
- mem_addr  out  32  RAM address
- mem_wr_data  out  32  RAM write data
- mem_wr_en  out  1  RAM write enable
- mem_rd_en  out  1  RAM read enable
- mem_size  out  2  RAM access size
- mem_zero_ext  out  1  RAM zero-extend
- mem_rd_data  in  32  RAM read data, valid 1 cycle after mem_rd_en
- stall_req  out  1  arbiter stall request to hazard unit

Behaviour:
- Lane request: reqN = lN_rd_en | lN_wr_en.
  - If both lN_rd_en and lN_wr_en are high, the read is taken and the write is ignored (illegal encoding; the bench flags it).
- FSM states: IDLE, SECOND.
- IDLE, no request: all mem_* enables 0; mem_addr/mem_wr_data/mem_size/mem_zero_ext are 0.
- IDLE, single request from lane N: lane N fields are muxed combinationally onto mem_*. stall_req = 0. Stay in IDLE.
- IDLE, both lanes request: the winner is muxed onto mem_* this cycle and stall_req = 1.
  - Winner selection, mixed read/write: the read lane wins, so reads see pre-bundle memory. The priority pointer is unchanged.
  - Winner selection, read/read or write/write: the pointer lane wins. The pointer flips to the other lane at the clock edge.
  - At the clock edge, the loser's full request is latched into a pending register, the winner id and "winner was read" are registered, and the FSM goes to SECOND.
- SECOND (always exactly 1 cycle):
  - The pending request drives mem_*. stall_req = 0.
  - If the winner was a read, mem_rd_data is captured into hold_data and hold_valid[winner] is set at the edge.
  - Next state is IDLE. Inputs are ignored in SECOND.
- Read return routing: lN_rd_data = hold_valid[N] ? hold_data : mem_rd_data.
- hold_valid clears on the first edge where stall_in = 0 after it is set. It is held while stall_in = 1.
- Two writes to the same address: the second-issued write persists.
- stall_in in IDLE: the arbiter keeps issuing the presented request each cycle. Repeated reads and writes are idempotent, so no special handling.
- Reset (rst = 0 at an edge), including mid-SECOND:
  - FSM to IDLE; pointer = RR_INIT.
  - hold_valid = 0, hold_data = 0, pending cleared.
  - While rst = 0: all mem enables 0, stall_req = 0, lN_rd_data = 0.
- Latency: uncontended read data arrives 1 cycle after the request. Contended requests take 2 cycles with a 1-cycle stall_req pulse.

Optional Feature:
- Macro: LSU_ARB_PERF_EN.
- Defined: adds output conflict_cnt (32 bits). It increments on every IDLE cycle with both lanes requesting, saturates at 0xFFFFFFFF, and clears on reset.
- Undefined: no port and no counter logic.

Test Plan:
- Lane 0 reads 0x100 alone, RAM returns 0xDEADBEEF -> mem_addr = 0x100 same cycle, stall_req = 0, l0_rd_data = 0xDEADBEEF next cycle.
- Both lanes read (0x10 → 0x11111111, 0x20 → 0x22222222), pointer = 0:
  - cycle t: lane 0 issued, stall_req = 1.
  - cycle t+1: lane 1 issued at 0x20.
  - cycle t+2: l0_rd_data = 0x11111111 from the hold register, l1_rd_data = 0x22222222.
  - The next conflict is won by lane 1.
- Lane 0 writes 0xAA to 0x40 while lane 1 reads 0x40 (old value 0x55) -> read issued first, l1_rd_data = 0x55, write issued in SECOND, pointer unchanged.
- Two writes to 0x80 (lane 0: 1, lane 1: 2), pointer = 1 -> lane 1 written first, lane 0 second; RAM holds 1.
- Read/read conflict with stall_in = 1 for 3 cycles after SECOND -> l0_rd_data holds the buffered value until stall_in falls, then follows mem_rd_data.
- rst = 0 asserted during SECOND -> next cycle IDLE, mem_wr_en = 0, stall_req = 0, pointer = RR_INIT.
- With LSU_ARB_PERF_EN defined: 5 conflicts -> conflict_cnt = 5.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_mem_arbiter
//
// Shares the single data-RAM port between the two LSU lanes of one VLIW
// bundle. A request from one lane is passed straight through to the RAM in
// the same cycle. When both lanes request in the same cycle, the accesses are
// serialised over two cycles. The block raises stall_req for one cycle, and
// it buffers the first lane's read data so that both lanes see correct
// writeback data.
//
// Optional feature: define LSU_ARB_PERF_EN to add the conflict_cnt output.
// This saturating counter counts the cycles on which both lanes contend.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   stall_in          stall from the hazard unit (other sources); holds the
//                     buffered read data while high
//   lN_rd_*           lane N read request: enable, address, size, zero-extend
//   lN_wr_*           lane N write request: enable, address, data, size
//   lN_rd_data        read data to lane N writeback
//   mem_*             single RAM port; mem_rd_data is valid 1 cycle after
//                     mem_rd_en
//   stall_req         arbiter stall request to the hazard unit
//   conflict_cnt      (LSU_ARB_PERF_EN only) number of contended cycles
//
// Handshake: the arbiter accepts a lane request in the cycle it is presented.
// If stall_req is high in that cycle, the arbiter has captured the losing
// request. The bundle must then stay put for exactly one more cycle, and the
// arbiter ignores the lane inputs in that cycle. There is no ready signal
// beyond stall_req.
// -----------------------------------------------------------------------------
module lsu_mem_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        l0_rd_en,
    input  logic [31:0] l0_rd_addr,
    input  logic [1:0]  l0_rd_size,
    input  logic        l0_rd_zero_ext,
    input  logic        l0_wr_en,
    input  logic [31:0] l0_wr_addr,
    input  logic [31:0] l0_wr_data,
    input  logic [1:0]  l0_wr_size,
    input  logic        l1_rd_en,
    input  logic [31:0] l1_rd_addr,
    input  logic [1:0]  l1_rd_size,
    input  logic        l1_rd_zero_ext,
    input  logic        l1_wr_en,
    input  logic [31:0] l1_wr_addr,
    input  logic [31:0] l1_wr_data,
    input  logic [1:0]  l1_wr_size,
    output logic [31:0] l0_rd_data,
    output logic [31:0] l1_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [1:0]  mem_size,
    output logic        mem_zero_ext,
    input  logic [31:0] mem_rd_data,
    output logic        stall_req
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [31:0] conflict_cnt
`endif
);

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        zext;
    } req_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // If rd_en and wr_en are both high, the read is taken and the write is dropped.
    function automatic req_t decode_req(
        input logic        rd_en,
        input logic [31:0] rd_addr,
        input logic [1:0]  rd_size,
        input logic        rd_zero_ext,
        input logic        wr_en,
        input logic [31:0] wr_addr,
        input logic [31:0] wr_data,
        input logic [1:0]  wr_size
    );
        req_t r;
        r = '0;
        if (rd_en) begin
            r.rd   = 1'b1;
            r.addr = rd_addr;
            r.size = rd_size;
            r.zext = rd_zero_ext;
        end else if (wr_en) begin
            r.wr   = 1'b1;
            r.addr = wr_addr;
            r.data = wr_data;
            r.size = wr_size;
        end
        return r;
    endfunction

    state_t      state;
    state_t      next_state;
    req_t        req0;
    req_t        req1;
    req_t        pend;
    req_t        sel;
    logic        any0;
    logic        any1;
    logic        arb_cycle;
    logic        mixed;
    logic        win;
    logic        ptr;
    logic        win_id;
    logic        win_rd;
    logic [1:0]  hold_valid;
    logic [31:0] hold_data;

    assign req0 = decode_req(l0_rd_en, l0_rd_addr, l0_rd_size, l0_rd_zero_ext,
                             l0_wr_en, l0_wr_addr, l0_wr_data, l0_wr_size);
    assign req1 = decode_req(l1_rd_en, l1_rd_addr, l1_rd_size, l1_rd_zero_ext,
                             l1_wr_en, l1_wr_addr, l1_wr_data, l1_wr_size);

    assign any0      = req0.rd | req0.wr;
    assign any1      = req1.rd | req1.wr;
    assign arb_cycle = (state == IDLE) && any0 && any1;
    // Read/write mix: the read goes first so that it sees pre-bundle memory.
    assign mixed     = req0.rd ^ req1.rd;
    assign win       = mixed ? req1.rd : ptr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: SECOND always lasts exactly one cycle
    always_comb begin
        next_state = IDLE;
        if (arb_cycle) begin
            next_state = SECOND;
        end
    end

    // Output logic
    always_comb begin
        sel = '0;
        if (state == SECOND) begin
            sel = pend;
        end else if (any0 && any1) begin
            sel = win ? req1 : req0;
        end else if (any0) begin
            sel = req0;
        end else if (any1) begin
            sel = req1;
        end
        if (!rst) begin
            sel = '0;
        end
        mem_addr     = sel.addr;
        mem_wr_data  = sel.data;
        mem_wr_en    = sel.wr;
        mem_rd_en    = sel.rd;
        mem_size     = sel.size;
        mem_zero_ext = sel.zext;
        stall_req    = rst && arb_cycle;
        l0_rd_data   = '0;
        l1_rd_data   = '0;
        if (rst) begin
            l0_rd_data = hold_valid[0] ? hold_data : mem_rd_data;
            l1_rd_data = hold_valid[1] ? hold_data : mem_rd_data;
        end
    end

    // Pending request, priority pointer and read-data buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr        <= RR_INIT;
            pend       <= '0;
            win_id     <= 1'b0;
            win_rd     <= 1'b0;
            hold_valid <= 2'b00;
            hold_data  <= '0;
        end else begin
            if (arb_cycle) begin
                pend   <= win ? req0 : req1;
                win_id <= win;
                win_rd <= win ? req1.rd : req0.rd;
                if (!mixed) begin
                    ptr <= ~ptr;
                end
            end
            // The winner's read data returns during SECOND; it must survive
            // until the pipeline moves past an external stall.
            if ((state == SECOND) && win_rd) begin
                hold_data  <= mem_rd_data;
                hold_valid <= (stall_in ? hold_valid : 2'b00) |
                              (win_id ? 2'b10 : 2'b01);
            end else if (!stall_in) begin
                hold_valid <= 2'b00;
            end
        end
    end

`ifdef LSU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (arb_cycle && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
module tb_lsu_mem_arbiter;

    localparam bit RR_INIT = 1'b0;
    localparam int ACC_W   = 70;

    // ---------------------------------------------------------------- clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic        stall_in;
    logic        l0_rd_en, l0_rd_zero_ext, l0_wr_en;
    logic [31:0] l0_rd_addr, l0_wr_addr, l0_wr_data;
    logic [1:0]  l0_rd_size, l0_wr_size;
    logic        l1_rd_en, l1_rd_zero_ext, l1_wr_en;
    logic [31:0] l1_rd_addr, l1_wr_addr, l1_wr_data;
    logic [1:0]  l1_rd_size, l1_wr_size;
    logic [31:0] l0_rd_data, l1_rd_data;
    logic [31:0] mem_addr, mem_wr_data;
    logic        mem_wr_en, mem_rd_en, mem_zero_ext;
    logic [1:0]  mem_size;
    logic [31:0] rdq;
    logic        stall_req;
`ifdef LSU_ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    lsu_mem_arbiter #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .l0_rd_en(l0_rd_en), .l0_rd_addr(l0_rd_addr), .l0_rd_size(l0_rd_size),
        .l0_rd_zero_ext(l0_rd_zero_ext), .l0_wr_en(l0_wr_en), .l0_wr_addr(l0_wr_addr),
        .l0_wr_data(l0_wr_data), .l0_wr_size(l0_wr_size),
        .l1_rd_en(l1_rd_en), .l1_rd_addr(l1_rd_addr), .l1_rd_size(l1_rd_size),
        .l1_rd_zero_ext(l1_rd_zero_ext), .l1_wr_en(l1_wr_en), .l1_wr_addr(l1_wr_addr),
        .l1_wr_data(l1_wr_data), .l1_wr_size(l1_wr_size),
        .l0_rd_data(l0_rd_data), .l1_rd_data(l1_rd_data),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_size(mem_size), .mem_zero_ext(mem_zero_ext),
        .mem_rd_data(rdq), .stall_req(stall_req)
`ifdef LSU_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    // ---------------------------------------------------------------- RAM behind the port
    logic [31:0] ram [256];
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        else if (mem_wr_en) ram[mem_addr[9:2]] <= mem_wr_data;
        if (mem_rd_en) rdq <= ram[mem_addr[9:2]];
    end

    // ---------------------------------------------------------------- reference model state
    logic [31:0]      mm [256];        // memory contents as the program sees them
    bit               mptr;            // round-robin priority lane
    logic [31:0]      model_conflicts;
    logic [ACC_W-1:0] exp_q[$];        // expected RAM accesses, in issue order
    logic [31:0]      exp_rd0_q[$];    // expected writeback data, lane 0
    logic [31:0]      exp_rd1_q[$];    // expected writeback data, lane 1
    logic [31:0]      last_rd0, last_rd1;
    int               checks, errors;

    // Bundle description: kind 0 none, 1 read, 2 write, 3 read+write (illegal)
    int          bk [2];
    logic [31:0] ba [2];
    logic [31:0] bd [2];
    logic [1:0]  bs [2];
    logic        bz [2];

    logic wb0, wb1;       // writeback of lane N is being presented this cycle
    logic carry0, carry1; // lane N read needs a writeback check next cycle

    function automatic logic [ACC_W-1:0] mk_acc(input logic st, input logic rd, input logic wr,
                                                input logic [31:0] a, input logic [31:0] d,
                                                input logic [1:0] s, input logic z);
        logic [31:0] dm;
        logic        zm;
        dm = wr ? d : 32'h0;
        zm = rd ? z : 1'b0;
        return {st, rd, wr, a, dm, s, zm};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic drive_lane(input int lane, input int k, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s, input logic z);
        logic        r, w;
        logic [31:0] wa;
        logic [1:0]  ws;
        r  = (k == 1) || (k == 3);
        w  = (k == 2) || (k == 3);
        wa = (k == 3) ? $urandom : a;
        ws = (k == 3) ? 2'($urandom_range(0, 2)) : s;
        if (lane == 0) begin
            l0_rd_en = r; l0_wr_en = w; l0_rd_addr = a; l0_wr_addr = wa;
            l0_wr_data = d; l0_rd_size = s; l0_wr_size = ws; l0_rd_zero_ext = z;
        end else begin
            l1_rd_en = r; l1_wr_en = w; l1_rd_addr = a; l1_wr_addr = wa;
            l1_wr_data = d; l1_rd_size = s; l1_wr_size = ws; l1_rd_zero_ext = z;
        end
    endtask

    task automatic clear_lanes();
        drive_lane(0, 0, 32'h0, 32'h0, 2'd0, 1'b0);
        drive_lane(1, 0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic idle_cycle();
        clear_lanes();
        wb0 = carry0; wb1 = carry1;
        carry0 = 1'b0; carry1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = 8'(idx); poke_val = val;
        mm[idx] = val;
        idle_cycle();
        poke_en = 1'b0;
    endtask

    task automatic rand_bundle();
        for (int i = 0; i < 2; i++) begin
            bk[i] = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            ba[i] = 32'($urandom_range(0, 15)) << 2;
            bd[i] = $urandom;
            bs[i] = 2'($urandom_range(0, 2));
            bz[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Compute the expected outcome of a bundle from the sharing rules, then
    // present it for one cycle, or for two when both lanes contend.
    task automatic run_bundle();
        int rk [2];
        int order[$];
        int first;
        bit both;
        for (int i = 0; i < 2; i++) begin
            rk[i] = (bk[i] == 3) ? 1 : bk[i];
            if (bk[i] == 3) $display("note: lane %0d drives rd_en and wr_en together; read taken", i);
        end
        both = (rk[0] != 0) && (rk[1] != 0);
        order = {};
        if (both) begin
            model_conflicts++;
            if (rk[0] != rk[1]) first = (rk[0] == 1) ? 0 : 1;
            else begin
                first = int'(mptr);
                mptr = ~mptr;
            end
            order.push_back(first);
            order.push_back(1 - first);
        end else if (rk[0] != 0) order.push_back(0);
        else if (rk[1] != 0) order.push_back(1);
        foreach (order[n]) begin
            int ln;
            ln = order[n];
            exp_q.push_back(mk_acc(both && (n == 0), rk[ln] == 1, rk[ln] == 2,
                                   ba[ln], bd[ln], bs[ln], bz[ln]));
            if (rk[ln] == 1) begin
                if (ln == 0) begin exp_rd0_q.push_back(mm[ba[0][9:2]]); last_rd0 = mm[ba[0][9:2]]; end
                else begin exp_rd1_q.push_back(mm[ba[1][9:2]]); last_rd1 = mm[ba[1][9:2]]; end
            end else begin
                mm[ba[ln][9:2]] = bd[ln];
            end
        end
        drive_lane(0, bk[0], ba[0], bd[0], bs[0], bz[0]);
        drive_lane(1, bk[1], ba[1], bd[1], bs[1], bz[1]);
        wb0 = carry0; wb1 = carry1;
        @(posedge clk); #1;
        if (both) begin
            // Inputs are don't-care in the second cycle; scramble them.
            drive_lane(0, int'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            drive_lane(1, int'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wb0 = 1'b0; wb1 = 1'b0;
            @(posedge clk); #1;
        end
        carry0 = (rk[0] == 1);
        carry1 = (rk[1] == 1);
    endtask

    // ---------------------------------------------------------------- monitor / scoreboard
    always @(negedge clk) begin
        logic [ACC_W-1:0] got, e;
        if (mem_rd_en || mem_wr_en) begin
            checks++;
            got = mk_acc(stall_req, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_size, mem_zero_ext);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL access: unexpected RAM access %h, none expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL access: got {stall,rd,wr,addr,data,size,zext}=%h expected %h", got, e);
                end
            end
        end else if (rst) begin
            checks++;
            if ({stall_req, mem_addr, mem_wr_data, mem_size, mem_zero_ext} !== 68'h0) begin
                errors++;
                $display("FAIL idle_port: stall=%b addr=%h data=%h size=%0d zext=%b expected all zero",
                         stall_req, mem_addr, mem_wr_data, mem_size, mem_zero_ext);
            end
        end
        if (wb0) begin
            checks++;
            if (exp_rd0_q.size() == 0) begin
                errors++;
                $display("FAIL l0_rd_data: got %h, no expected value queued", l0_rd_data);
            end else begin
                e[31:0] = exp_rd0_q.pop_front();
                if (l0_rd_data !== e[31:0]) begin
                    errors++;
                    $display("FAIL l0_rd_data: got %h expected %h", l0_rd_data, e[31:0]);
                end
            end
        end
        if (wb1) begin
            checks++;
            if (exp_rd1_q.size() == 0) begin
                errors++;
                $display("FAIL l1_rd_data: got %h, no expected value queued", l1_rd_data);
            end else begin
                e[31:0] = exp_rd1_q.pop_front();
                if (l1_rd_data !== e[31:0]) begin
                    errors++;
                    $display("FAIL l1_rd_data: got %h expected %h", l1_rd_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main sequence
    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; stall_in = 1'b0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        wb0 = 1'b0; wb1 = 1'b0; carry0 = 1'b0; carry1 = 1'b0;
        mptr = RR_INIT; model_conflicts = '0;
        last_rd0 = '0; last_rd1 = '0;

        // Reset with a contended bundle presented: everything must stay quiet.
        drive_lane(0, 1, 32'h10, 32'h0, 2'd2, 1'b0);
        drive_lane(1, 2, 32'h20, 32'h1234, 2'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_mem_rd_en", 32'(mem_rd_en), 32'h0);
        chk("reset_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("reset_stall_req", 32'(stall_req), 32'h0);
        chk("reset_l0_rd_data", l0_rd_data, 32'h0);
        chk("reset_l1_rd_data", l1_rd_data, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        rst = 1'b1;
        idle_cycle();

        // Uncontended read of 0x100.
        poke(32'h100 >> 2, 32'hDEADBEEF);
        bk = '{1, 0}; ba = '{32'h100, 32'h0}; bd = '{0, 0}; bs = '{2'd2, 2'd0}; bz = '{0, 0};
        run_bundle();
        idle_cycle();

        // Read/read conflict with the pointer at lane 0.
        poke(32'h10 >> 2, 32'h11111111);
        poke(32'h20 >> 2, 32'h22222222);
        bk = '{1, 1}; ba = '{32'h10, 32'h20}; bs = '{2'd2, 2'd2}; bz = '{0, 1};
        run_bundle();
        // Write/write to 0x80: lane 1 holds the pointer now.
        bk = '{2, 2}; ba = '{32'h80, 32'h80}; bd = '{32'h1, 32'h2}; bs = '{2'd2, 2'd2};
        run_bundle();
        // Write/read mix on 0x40: the read sees the old value.
        poke(32'h40 >> 2, 32'h55);
        bk = '{2, 1}; ba = '{32'h40, 32'h40}; bd = '{32'hAA, 32'h0}; bs = '{2'd0, 2'd0};
        run_bundle();
        // Read back 0x80 and 0x40.
        bk = '{1, 0}; ba = '{32'h80, 32'h0}; bs = '{2'd2, 2'd0};
        run_bundle();
        bk = '{0, 1}; ba = '{32'h0, 32'h40}; bs = '{2'd0, 2'd1};
        run_bundle();
        idle_cycle();

        // Read/read conflict followed by three cycles of external stall.
        bk = '{1, 1}; ba = '{32'h0C, 32'h14}; bs = '{2'd2, 2'd2}; bz = '{0, 0};
        run_bundle();
        stall_in = 1'b1;
        idle_cycle();
        for (int i = 0; i < 2; i++) begin
            exp_rd0_q.push_back(last_rd0); exp_rd1_q.push_back(last_rd1);
            carry0 = 1'b1; carry1 = 1'b1;
            idle_cycle();
        end
        stall_in = 1'b0;
        exp_rd0_q.push_back(last_rd0); exp_rd1_q.push_back(last_rd1);
        carry0 = 1'b1; carry1 = 1'b1;
        bk = '{0, 1}; ba = '{32'h0, 32'h24}; bs = '{2'd0, 2'd2};
        run_bundle();
        // The buffer has been released: lane 0 now follows the RAM data.
        exp_rd0_q.push_back(mm[8'h24 >> 2]);
        carry0 = 1'b1;
        idle_cycle();

        // Reset asserted during the second cycle of a write/write conflict.
        if (mptr != RR_INIT) begin
            bk = '{1, 1}; ba = '{32'h30, 32'h34}; bs = '{2'd2, 2'd2};
            run_bundle();
            idle_cycle();
        end
        bk = '{2, 2}; ba = '{32'h60, 32'h64}; bd = '{32'h600D0000, 32'h600D0001}; bs = '{2'd2, 2'd2};
        exp_q.push_back(mk_acc(1'b1, 1'b0, 1'b1, ba[int'(mptr)], bd[int'(mptr)], bs[int'(mptr)], 1'b0));
        mm[ba[int'(mptr)][9:2]] = bd[int'(mptr)];
        drive_lane(0, bk[0], ba[0], bd[0], bs[0], 1'b0);
        drive_lane(1, bk[1], ba[1], bd[1], bs[1], 1'b0);
        wb0 = carry0; wb1 = carry1; carry0 = 1'b0; carry1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_lanes();
        wb0 = 1'b0; wb1 = 1'b0;
        @(negedge clk);
        chk("rst_second_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_second_mem_rd_en", 32'(mem_rd_en), 32'h0);
        chk("rst_second_stall_req", 32'(stall_req), 32'h0);
        chk("rst_second_l0_rd_data", l0_rd_data, 32'h0);
        chk("rst_second_l1_rd_data", l1_rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mptr = RR_INIT;
        model_conflicts = '0;
        @(negedge clk);
        chk("post_rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("post_rst_stall_req", 32'(stall_req), 32'h0);
        @(posedge clk); #1;
        // The pointer must be back at RR_INIT: a write/write pair reveals the order.
        bk = '{2, 2}; ba = '{32'h68, 32'h6C}; bd = '{$urandom, $urandom}; bs = '{2'd1, 2'd2};
        run_bundle();
        bk = '{1, 1}; ba = '{32'h60, 32'h64}; bs = '{2'd2, 2'd2};
        run_bundle();

        // Randomised bundles over a small address set to force collisions.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            else begin
                rand_bundle();
                run_bundle();
            end
        end

        repeat (3) idle_cycle();
        @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        chk("exp_rd0_q_empty", 32'(exp_rd0_q.size()), 32'h0);
        chk("exp_rd1_q_empty", 32'(exp_rd1_q.size()), 32'h0);
`ifdef LSU_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, model_conflicts);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
